wb_request_arbiter: RTL

- Shares the single Wishbone bus manager between two requesters: instruction fetch (I-port, read-only) and data memory (D-port, read/write).
- Picks one requester, latches its request, sequences the manager's READ/WRITE/BUSY/ACK handshake, and returns read data plus a one-cycle ack to the granted port.
- Sits between the CPU core and the bus manager. The manager's ports connect directly to the M_* ports.

---
 rtl/wb_request_arbiter_if.sv | 44 ++++
 rtl/wb_request_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wb_request_arbiter_if.sv
// wb_request_arbiter_if: bundles the I-port, D-port and bus-manager signals
// of the request arbiter. The master modport is the arbiter's own view (it
// drives the manager strobes and the port acks); the slave modport is the
// surrounding environment (CPU requesters plus the bus manager).
`timescale 1ns/1ps
interface wb_request_arbiter_if;
   logic        I_REQ;
   logic [31:0] I_ADR;
   logic [31:0] I_RDAT;
   logic        I_ACK;

   logic        D_REQ;
   logic        D_WE;
   logic [31:0] D_ADR;
   logic [31:0] D_WDAT;
   logic [3:0]  D_SEL;
   logic [31:0] D_RDAT;
   logic        D_ACK;

   logic        M_READ_O;
   logic        M_WRITE_O;
   logic [31:0] M_ADR_O;
   logic [31:0] M_DAT_O;
   logic [3:0]  M_SEL_O;
   logic [31:0] M_DAT_I;
   logic        M_BUSY_I;
   logic        M_ACK_I;

   logic [1:0]  GRANT_O;

   modport master (
      input  I_REQ, I_ADR, D_REQ, D_WE, D_ADR, D_WDAT, D_SEL,
      input  M_DAT_I, M_BUSY_I, M_ACK_I,
      output I_RDAT, I_ACK, D_RDAT, D_ACK,
      output M_READ_O, M_WRITE_O, M_ADR_O, M_DAT_O, M_SEL_O, GRANT_O
   );

   modport slave (
      output I_REQ, I_ADR, D_REQ, D_WE, D_ADR, D_WDAT, D_SEL,
      output M_DAT_I, M_BUSY_I, M_ACK_I,
      input  I_RDAT, I_ACK, D_RDAT, D_ACK,
      input  M_READ_O, M_WRITE_O, M_ADR_O, M_DAT_O, M_SEL_O, GRANT_O
   );
endinterface

// File: rtl/wb_request_arbiter.sv
// wb_request_arbiter: shares one Wishbone bus manager between the instruction
// fetch port (read-only) and the data port (read/write). One request is
// latched at a time and walked through ISSUE -> WAIT -> DONE.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between the ports instead
// of fixed D priority with the STARVE_LIMIT escape for I.
`timescale 1ns/1ps
module wb_request_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                  CLK,
   input logic                  nRST,
   wb_request_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        we_q;
   logic [31:0] adr_q;
   logic [31:0] wdat_q;
   logic [3:0]  sel_q;
   logic [31:0] i_rdat_q;
   logic [31:0] d_rdat_q;
   logic        arb_go;
   logic        pick_i;
   logic        done_rd;
   logic        rd_o, wr_o, i_ack_o, d_ack_o;

   // A grant happens only from IDLE, with the manager free and someone asking.
   assign arb_go  = (state_q == IDLE) && !bus.M_BUSY_I && (bus.I_REQ || bus.D_REQ);
   assign done_rd = (state_q == DONE) && !we_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q;

   assign pick_i = bus.I_REQ && (!bus.D_REQ || last_d_q);

   // Remember the latest winner so the next tie goes to the other port.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)       last_d_q <= 1'b0;
      else if (arb_go) last_d_q <= !pick_i;
   end
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_q;

   // D wins ties until I has been passed over LIMIT times in a row.
   assign pick_i = bus.I_REQ &&
                   (!bus.D_REQ || ((LIMIT != 4'd0) && (starve_q == LIMIT)));

   // Count D grants that made a waiting I stand aside; any I grant clears it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         starve_q <= 4'd0;
      end else if (arb_go) begin
         if (pick_i)
            starve_q <= 4'd0;
         else if (bus.I_REQ && (starve_q != LIMIT))
            starve_q <= starve_q + 4'd1;
      end
   end
`endif

   // State and owner registers; reset aborts any transaction without an ack.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // Next-state logic plus the one-cycle strobe and ack pulses.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rd_o    = 1'b0;
      wr_o    = 1'b0;
      i_ack_o = 1'b0;
      d_ack_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_go) begin
               state_d = ISSUE;
               grant_d = pick_i ? 2'b01 : 2'b10;
            end
         end
         ISSUE: begin
            rd_o    = !we_q;
            wr_o    = we_q;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.M_ACK_I) state_d = DONE;
         end
         DONE: begin
            i_ack_o = grant_q[0];
            d_ack_o = grant_q[1];
            grant_d = 2'b00;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the winning request so the manager sees stable values throughout.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         adr_q  <= 32'd0;
         wdat_q <= 32'd0;
         sel_q  <= 4'd0;
         we_q   <= 1'b0;
      end else if (arb_go) begin
         if (pick_i) begin
            adr_q  <= bus.I_ADR;
            wdat_q <= 32'd0;
            sel_q  <= 4'hF;
            we_q   <= 1'b0;
         end else begin
            adr_q  <= bus.D_ADR;
            wdat_q <= bus.D_WDAT;
            sel_q  <= bus.D_SEL;
            we_q   <= bus.D_WE;
         end
      end
   end

   // Keep the last read result per port; writes leave it untouched.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         i_rdat_q <= 32'd0;
         d_rdat_q <= 32'd0;
      end else if (done_rd) begin
         if (grant_q[0]) i_rdat_q <= bus.M_DAT_I;
         if (grant_q[1]) d_rdat_q <= bus.M_DAT_I;
      end
   end

   // Manager data arrives in the DONE cycle, so it is forwarded alongside the ack.
   assign bus.I_RDAT    = (done_rd && grant_q[0]) ? bus.M_DAT_I : i_rdat_q;
   assign bus.D_RDAT    = (done_rd && grant_q[1]) ? bus.M_DAT_I : d_rdat_q;
   assign bus.I_ACK     = i_ack_o;
   assign bus.D_ACK     = d_ack_o;
   assign bus.M_READ_O  = rd_o;
   assign bus.M_WRITE_O = wr_o;
   assign bus.M_ADR_O   = (state_q == IDLE) ? 32'd0 : adr_q;
   assign bus.M_DAT_O   = (state_q == IDLE) ? 32'd0 : wdat_q;
   assign bus.M_SEL_O   = (state_q == IDLE) ? 4'd0  : sel_q;
   assign bus.GRANT_O   = grant_q;

endmodule
